// File: rtl/serial_word_comparator_ctrl.sv
// rtl/serial_word_comparator_ctrl.sv - MSB-first word compare sequencer driving one shared 1-bit comparator
module serial_word_comparator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic [2:0]       cmp_y,
  output logic             busy,
  output logic             done,
  output logic [2:0]       y,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [2:0] Y_GT = 3'b100;
  localparam logic [2:0] Y_LT = 3'b010;
  localparam logic [2:0] Y_EQ = 3'b001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]   idx;
  logic            last_bit;

  assign last_bit = (idx == '0);

  // State register; reset aborts any in-flight comparison without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: decide on first unequal bit, illegal code, or after the LSB
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COMPARE;
          accept    = 1'b1;
        end
      end
      COMPARE: begin
        case (cmp_y)
          Y_GT, Y_LT: state_nxt = DONE;
          Y_EQ:       state_nxt = last_bit ? DONE : COMPARE;
          default:    state_nxt = DONE;
        endcase
      end
      DONE: begin
        if (start) begin
          state_nxt = COMPARE;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit index walk and result/error registration
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
      y     <= 3'b000;
      err   <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      idx   <= IW'(WIDTH - 1);
      y     <= 3'b000;
      err   <= 1'b0;
    end else if (state == COMPARE) begin
      case (cmp_y)
        Y_GT, Y_LT: y <= cmp_y;
        Y_EQ: begin
          if (last_bit) begin
            y <= Y_EQ;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: begin
          y   <= 3'b000;
          err <= 1'b1;
        end
      endcase
    end
  end

  // Comparator inputs are only driven while comparing so the shared cell sees zeros otherwise
  always_comb begin
    cmp_a = 1'b0;
    cmp_b = 1'b0;
    if (state == COMPARE) begin
      cmp_a = a_reg[idx];
      cmp_b = b_reg[idx];
    end
  end

  assign busy = (state == COMPARE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_word_comparator_ctrl.sv
// tb/tb_serial_word_comparator_ctrl.sv - directed self-checking bench for serial_word_comparator_ctrl
module tb_serial_word_comparator_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cmp_a;
  logic       cmp_b;
  logic [2:0] cmp_y;
  logic       busy;
  logic       done;
  logic [2:0] y;
  logic       err;

  logic       inject;
  logic [2:0] inject_code;

  int checks   = 0;
  int failures = 0;

  serial_word_comparator_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cmp_a (cmp_a),
    .cmp_b (cmp_b),
    .cmp_y (cmp_y),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .err   (err)
  );

  // 1-bit comparator with a fault-injection override
  always_comb begin
    cmp_y = {cmp_a & ~cmp_b, ~cmp_a & cmp_b, cmp_a == cmp_b};
    if (inject) cmp_y = inject_code;
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done, counting cycles after the accepting edge and capturing the bits presented
  task automatic wait_done(output int n, output logic [7:0] abits, output logic [7:0] bbits, output int busy_cycles);
    n = 0;
    abits = '0;
    bbits = '0;
    busy_cycles = 0;
    while (!done && n < 40) begin
      if (busy) begin
        abits = {abits[6:0], cmp_a};
        bbits = {bbits[6:0], cmp_b};
        busy_cycles++;
      end
      tick();
      n++;
    end
    if (!done) check("done_timeout", 32'(n), 32'hFFFF);
  endtask

  task automatic launch(input logic [7:0] va, input logic [7:0] vb);
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int         n;
  int         bc;
  logic [7:0] ab;
  logic [7:0] bb;
  int         seen_done;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    inject = 1'b0;
    inject_code = 3'b000;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_y", 32'(y), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cmp", 32'({cmp_a, cmp_b}), 0);
    rst = 1'b0;
    tick();

    // MSB differs
    launch(8'h80, 8'h7F);
    check("msb_cmp", 32'({cmp_a, cmp_b}), 32'b10);
    check("msb_busy", 32'(busy), 1);
    wait_done(n, ab, bb, bc);
    check("msb_lat", 32'(n), 1);
    check("msb_busycyc", 32'(bc), 1);
    check("msb_y", 32'(y), 32'b100);
    check("msb_err", 32'(err), 0);
    check("msb_done_busy", 32'(busy), 0);
    tick();
    check("msb_done_pulse", 32'(done), 0);

    // LSB differs, full bit walk observed
    launch(8'h5A, 8'h5B);
    wait_done(n, ab, bb, bc);
    check("lsb_lat", 32'(n), 8);
    check("lsb_abits", 32'(ab), 32'h5A);
    check("lsb_bbits", 32'(bb), 32'h5B);
    check("lsb_y", 32'(y), 32'b010);
    tick();

    // Equal words, then hold
    launch(8'hC3, 8'hC3);
    wait_done(n, ab, bb, bc);
    check("eq_lat", 32'(n), 8);
    check("eq_y", 32'(y), 32'b001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("eq_hold_y", 32'(y), 32'b001);
      check("eq_hold_done", 32'(done), 0);
    end

    // Back-to-back with start ignored mid-COMPARE
    launch(8'h40, 8'h80);
    wait_done(n, ab, bb, bc);
    check("b2b1_y", 32'(y), 32'b010);
    a = 8'h01;
    b = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", 32'(busy), 1);
    check("b2b_clr_y", 32'(y), 0);
    tick();
    tick();
    a = 8'h00;
    b = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, ab, bb, bc);
    check("b2b_lat", 32'(n + 3), 8);
    check("b2b_y", 32'(y), 32'b100);
    tick();

    // Reset mid-operation
    launch(8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_y", 32'(y), 0);
    check("abort_cmp", 32'({cmp_a, cmp_b}), 0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen_done++;
      tick();
    end
    check("abort_no_done", 32'(seen_done), 0);
    launch(8'h10, 8'h20);
    wait_done(n, ab, bb, bc);
    check("fresh_lat", 32'(n), 3);
    check("fresh_y", 32'(y), 32'b010);
    tick();

    // Illegal comparator code in the third compare cycle
    launch(8'hAA, 8'hAA);
    tick();
    tick();
    inject = 1'b1;
    inject_code = 3'b011;
    tick();
    inject = 1'b0;
    check("fault_done", 32'(done), 1);
    check("fault_y", 32'(y), 0);
    check("fault_err", 32'(err), 1);
    tick();
    check("fault_err_hold", 32'(err), 1);
    launch(8'h01, 8'h02);
    check("fault_err_clr", 32'(err), 0);
    wait_done(n, ab, bb, bc);
    check("after_fault_y", 32'(y), 32'b010);
    check("after_fault_err", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_comparator_ctrl.md
# serial_word_comparator_ctrl

Sequencer that compares two WIDTH-bit unsigned words by time-sharing a single 1-bit comparator, one bit per clock, MSB first. It owns a start/done handshake toward the requester and drives the external 1-bit comparator's inputs, reading back its one-hot result. The result is stopped at the first unequal bit. It sits between a requesting datapath and one `comparator_1bit` instance. That instance uses the team's result encoding: 3'b100 a>b, 3'b010 a<b, 3'b001 a==b.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when accepting (see Operation)
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cmp_a  out  1  bit of A presented to 1-bit comparator
- cmp_b  out  1  bit of B presented to 1-bit comparator
- cmp_y  in  3  combinational result from 1-bit comparator
- busy  out  1  high while a comparison is in progress
- done  out  1  one-cycle pulse: y/err valid
- y  out  3  word result, same one-hot encoding as cmp_y
- err  out  1  comparator returned an illegal code

## Operation
- States: IDLE, COMPARE, DONE.
- Reset (any state, including mid-COMPARE): state←IDLE. busy, done, err, cmp_a, cmp_b = 0. y = 3'b000. The bit index and operand registers are cleared.
- Start is accepted in IDLE or DONE when start=1. On acceptance:
  - a and b are latched into operand registers.
  - idx←WIDTH-1, y←000, err←0, state←COMPARE.
- COMPARE:
  - busy=1.
  - cmp_a=a_reg[idx], cmp_b=b_reg[idx]. These are combinational from the registers, so valid for the whole cycle.
  - cmp_y is sampled at the end of each cycle:
    - 100 or 010: y←cmp_y, state←DONE.
    - 001 and idx==0: y←001, state←DONE.
    - 001 and idx>0: idx←idx-1, stay in COMPARE.
    - Any other code (000, 011, 101, 110, 111, including multi-hot): y←000, err←1, state←DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next state is COMPARE if start=1 (back-to-back), otherwise IDLE.
- y and err hold their values from DONE until the next accepted start or reset.
- start is ignored while in COMPARE. Changes to a/b during COMPARE have no effect.
- cmp_a and cmp_b are 0 outside COMPARE.
- idx is a $clog2(WIDTH)-bit down-counter. It never wraps, because COMPARE exits at idx==0.

## Timing
- Edge E0 samples start=1. COMPARE begins after E0.
- k = number of leading equal bits (0..WIDTH-1), for unequal words.
  - Unequal words: decision registered at edge E(k+1). done is high during the cycle after E(k+1).
  - Latency start→done is k+2 cycles; minimum 2 (MSB differs).
- Equal words: WIDTH compare cycles. done is high after E(WIDTH), for a latency of WIDTH+1.
- Illegal cmp_y: terminates at the edge that samples it, with the same latency rule as an unequal bit.
- Back-to-back: start=1 during DONE is accepted at the edge ending DONE. busy rises the next cycle with no IDLE gap.
- Reset asserted in any cycle takes effect at that edge. There is no done pulse for an aborted operation.

## Test plan
- WIDTH=8, with a real 1-bit comparator attached (all cases below):
  - a=0x80, b=0x7F, start at E0 → cmp_a=1, cmp_b=0 in cycle 1; done after E1 with y=100, err=0; busy high 1 cycle.
  - a=0x5A, b=0x5B → 7 equal bits, LSB differs; done after E8 with y=010; idx sequence 7..0 observed on cmp_a/cmp_b.
  - a=b=0xC3 → done after E8, y=001. y holds 001 for 5 idle cycles after done.
- Back-to-back: hold start=1 through DONE with new a=0x01, b=0x00 → second comparison begins with no IDLE cycle; second done after E8 of that run, y=100. Also pulse start mid-COMPARE and verify it is ignored.
- Reset mid-op: a=b=0xFF, assert rst after E4 → at next edge busy=0, y=000, cmp_a=cmp_b=0; no done pulse. A fresh start then completes normally.
- Fault: force cmp_y=3'b011 in cycle 3 → done after E3, y=000, err=1. err clears on the next accepted start.
